// File: rtl/contador_bcd_pkg.sv
// Shared BCD digit constants and helpers for the counter and the 7-segment decoders.
package contador_bcd_pkg;
    localparam int NIB_W = 4;

    typedef logic [NIB_W-1:0] nib_t;

    localparam nib_t BCD_MAX = NIB_W'(9);
    localparam nib_t BCD_MIN = NIB_W'(0);

    // Non-decimal nibbles (A-F) clamp to 9 so every digit stays decodable.
    function automatic nib_t sat_bcd(input nib_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction
endpackage

// File: rtl/contador_bcd_if.sv
// Control/data bundle of the BCD counter; master drives controls, slave returns the count.
interface contador_bcd_if
    import contador_bcd_pkg::*;
#(
    parameter int DIGITOS = 2
);
    logic                     habilitar;
    logic                     arriba;
    logic                     cargar;
    logic [NIB_W*DIGITOS-1:0] dato_carga;
    logic [NIB_W*DIGITOS-1:0] bcd;
    logic                     tick;
    logic                     acarreo;

    modport master (output habilitar, arriba, cargar, dato_carga,
                    input  bcd, tick, acarreo);
    modport slave  (input  habilitar, arriba, cargar, dato_carga,
                    output bcd, tick, acarreo);
endinterface

// File: rtl/contador_bcd_digito.sv
// Single decade counter 0-9 with load, up/down step and end-of-range flags.
module digito_bcd
    import contador_bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cargar,
    input  nib_t valor,
    input  logic paso,
    input  logic arriba,
    output nib_t q,
    output logic es9,
    output logic es0
);
    assign es9 = (q == BCD_MAX);
    assign es0 = (q == BCD_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (cargar) begin
            q <= valor;
        end else if (paso) begin
            if (arriba)
                q <= es9 ? BCD_MIN : q + nib_t'(1);
            else
                q <= es0 ? BCD_MAX : q - nib_t'(1);
        end
    end
endmodule

// File: rtl/contador_bcd.sv
// Multi-digit BCD up/down counter with prescaler, parallel load, step tick and wrap carry.
module contador_bcd
    import contador_bcd_pkg::*;
#(
    parameter int DIGITOS = 2,
    parameter int DIV     = 50_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    contador_bcd_if.slave  bus
);
    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0]             pre;
    logic                      step;
    logic                      wrap;
    logic [DIGITOS-1:0]        es9, es0, paso;
    logic [DIGITOS:0]          lo9, lo0;
    nib_t [DIGITOS-1:0]        q, valor;

    assign step = bus.habilitar && (pre == PRE_MAX) && !bus.cargar;

    // lo9[i]/lo0[i]: every digit below i sits at 9 / 0, i.e. digit i gets the carry/borrow.
    assign lo9[0] = 1'b1;
    assign lo0[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITOS; i++) begin : g_dig
            assign valor[i]  = sat_bcd(bus.dato_carga[NIB_W*i +: NIB_W]);
            assign lo9[i+1]  = lo9[i] & es9[i];
            assign lo0[i+1]  = lo0[i] & es0[i];
            assign paso[i]   = step & (bus.arriba ? lo9[i] : lo0[i]);

            digito_bcd u_dig (
                .clk    (clk),
                .rst_n  (rst_n),
                .cargar (bus.cargar),
                .valor  (valor[i]),
                .paso   (paso[i]),
                .arriba (bus.arriba),
                .q      (q[i]),
                .es9    (es9[i]),
                .es0    (es0[i])
            );
        end
    endgenerate

    assign wrap    = bus.arriba ? lo9[DIGITOS] : lo0[DIGITOS];
    assign bus.bcd = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (bus.cargar) begin
            pre <= '0;
        end else if (bus.habilitar) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tick    <= 1'b0;
            bus.acarreo <= 1'b0;
        end else begin
            bus.tick    <= step;
            bus.acarreo <= step & wrap;
        end
    end
endmodule

// File: tb/tb_contador_bcd.sv
// Scoreboard bench: stimulus queues expected steps (cycle, count, carry); monitors check each tick.
module tb_contador_bcd;
    typedef struct {
        int         cyc;
        logic [7:0] bcd;
        logic       aca;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q2[$];
    exp_t q1[$];

    contador_bcd_if #(.DIGITOS(2)) b2 ();
    contador_bcd_if #(.DIGITOS(1)) b1 ();

    contador_bcd #(.DIGITOS(2), .DIV(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    contador_bcd #(.DIGITOS(1), .DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push2(input int c, input logic [7:0] v, input logic a);
        exp_t e;
        e.cyc = c; e.bcd = v; e.aca = a;
        q2.push_back(e);
    endtask

    task automatic push1(input int c, input logic [7:0] v, input logic a);
        exp_t e;
        e.cyc = c; e.bcd = v; e.aca = a;
        q1.push_back(e);
    endtask

    task automatic load2(input logic [7:0] v);
        b2.cargar     = 1'b1;
        b2.dato_carga = v;
        @(negedge clk);
        b2.cargar     = 1'b0;
    endtask

    // Monitor for the 2-digit, DIV=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (b2.tick) begin
            if (q2.size() == 0) begin
                chk("d2_extra_tick", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("d2_step_cyc", 32'(cyc), 32'(e.cyc));
                chk("d2_step_bcd", 32'(b2.bcd), 32'(e.bcd));
                chk("d2_step_acarreo", 32'(b2.acarreo), 32'(e.aca));
            end
        end else begin
            if (b2.acarreo) chk("d2_acarreo_no_tick", 32'd1, 32'd0);
            if (q2.size() > 0 && q2[0].cyc <= cyc) begin
                e = q2.pop_front();
                chk("d2_missing_tick", 32'd0, 32'd1);
            end
        end
    end

    // Monitor for the 1-digit, DIV=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (b1.tick) begin
            if (q1.size() == 0) begin
                chk("d1_extra_tick", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("d1_step_cyc", 32'(cyc), 32'(e.cyc));
                chk("d1_step_bcd", 32'(b1.bcd), 32'(e.bcd));
                chk("d1_step_acarreo", 32'(b1.acarreo), 32'(e.aca));
            end
        end else begin
            if (b1.acarreo) chk("d1_acarreo_no_tick", 32'd1, 32'd0);
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin
                e = q1.pop_front();
                chk("d1_missing_tick", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s1 [10];
        int t0, t1;
        s1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

        rst_n = 1'b0;
        b2.habilitar = 1'b0; b2.arriba = 1'b1; b2.cargar = 1'b0; b2.dato_carga = 8'h00;
        b1.habilitar = 1'b0; b1.arriba = 1'b1; b1.cargar = 1'b0; b1.dato_carga = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_bcd", 32'(b2.bcd), 32'h00);
        chk("reset_tick", 32'(b2.tick), 32'd0);
        chk("reset_acarreo", 32'(b2.acarreo), 32'd0);
        rst_n = 1'b1;

        // Count up 00..10, one step every 4 cycles
        t0 = cyc;
        b2.habilitar = 1'b1; b2.arriba = 1'b1;
        for (int k = 1; k <= 10; k++) push2(t0 + 4*k, s1[k-1], 1'b0);
        repeat (40) @(negedge clk);
        b2.habilitar = 1'b0;

        // Up wrap from 98
        load2(8'h98);
        chk("load_98", 32'(b2.bcd), 32'h98);
        chk("load_98_tick", 32'(b2.tick), 32'd0);
        t0 = cyc;
        b2.habilitar = 1'b1;
        push2(t0 + 4, 8'h99, 1'b0);
        push2(t0 + 8, 8'h00, 1'b1);
        push2(t0 + 12, 8'h01, 1'b0);
        repeat (12) @(negedge clk);
        b2.habilitar = 1'b0;

        // Down wrap from 00, then borrow across digits from 10
        b2.arriba = 1'b0;
        load2(8'h00);
        chk("load_00", 32'(b2.bcd), 32'h00);
        t0 = cyc;
        b2.habilitar = 1'b1;
        push2(t0 + 4, 8'h99, 1'b1);
        push2(t0 + 8, 8'h98, 1'b0);
        repeat (8) @(negedge clk);
        b2.habilitar = 1'b0;
        load2(8'h10);
        chk("load_10", 32'(b2.bcd), 32'h10);
        t0 = cyc;
        b2.habilitar = 1'b1;
        push2(t0 + 4, 8'h09, 1'b0);
        repeat (4) @(negedge clk);
        b2.habilitar = 1'b0;

        // Saturating load while disabled, then load colliding with a step
        load2(8'hAF);
        chk("load_AF_sat", 32'(b2.bcd), 32'h99);
        chk("load_AF_tick", 32'(b2.tick), 32'd0);
        b2.arriba = 1'b1;
        b2.habilitar = 1'b1;
        repeat (3) @(negedge clk);
        load2(8'h42);
        chk("load_in_step", 32'(b2.bcd), 32'h42);
        chk("load_in_step_tick", 32'(b2.tick), 32'd0);
        t1 = cyc;
        push2(t1 + 4, 8'h43, 1'b0);
        repeat (4) @(negedge clk);

        // Disable for 7 cycles with prescaler at DIV-1
        t1 = cyc;
        push2(t1 + 11, 8'h44, 1'b0);
        push2(t1 + 15, 8'h45, 1'b0);
        repeat (3) @(negedge clk);
        b2.habilitar = 1'b0;
        repeat (7) @(negedge clk);
        b2.habilitar = 1'b1;
        repeat (7) @(negedge clk);

        // Async reset between edges, prescaler mid-count
        #2 rst_n = 1'b0;
        b2.habilitar = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(b2.bcd), 32'h00);
        chk("async_rst_tick", 32'(b2.tick), 32'd0);
        chk("async_rst_acarreo", 32'(b2.acarreo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        b2.habilitar = 1'b1;
        push2(t0 + 4, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        b2.habilitar = 1'b0;

        // DIV=1, single digit: step every edge
        t0 = cyc;
        b1.habilitar = 1'b1; b1.arriba = 1'b1;
        for (int k = 1; k <= 10; k++) push1(t0 + k, 8'(k % 10), (k == 10));
        repeat (10) @(negedge clk);
        b1.habilitar = 1'b0;

        repeat (3) @(negedge clk);
        chk("d2_queue_drained", 32'(q2.size()), 32'd0);
        chk("d1_queue_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
